// File: rtl/timer_controller_if.sv
// Configuration bus between the processor side and the timer peripheral.
//   cfg_we    : one-cycle register write strobe
//   cfg_addr  : register select (0=CTRL, 1=PRESCALE, 2=COMPARE, 3=COUNT)
//   cfg_wdata : write data
//   irq_ack   : interrupt acknowledge
//   cfg_rdata : combinational read data of the register at cfg_addr
interface timer_controller_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        irq_ack;
  logic [31:0] cfg_rdata;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack,
    output cfg_rdata
  );
endinterface

// File: rtl/timer_controller.sv
// Programmable interval timer: prescaler, 32-bit tick counter, compare
// register and sticky compare-match interrupt; periodic or one-shot.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset
//   cfg     : register bus (slave side), cfg_rdata is combinational
//   count   : current counter value
//   tick    : one-cycle pulse following each counter update
//   irq     : sticky interrupt, set on match when irq_en, cleared by irq_ack
//   running : high while in RUN
module timer_controller #(
  parameter int unsigned PRESCALE_RESET = 49999
) (
  input  logic                clock,
  input  logic                reset,
  timer_controller_if.slave   cfg,
  output logic [31:0]         count,
  output logic                tick,
  output logic                irq,
  output logic                running
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] A_CTRL     = 2'd0;
  localparam logic [1:0] A_PRESCALE = 2'd1;
  localparam logic [1:0] A_COMPARE  = 2'd2;
  localparam logic [1:0] A_COUNT    = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic            enable_q, enable_d;
  logic            periodic_q, periodic_d;
  logic            irq_en_q, irq_en_d;
  logic [DW-1:0]   prescale_q, prescale_d;
  logic [DW-1:0]   compare_q, compare_d;
  logic [DW-1:0]   pre_q, pre_d;
  logic [DW-1:0]   count_q, count_d;
  logic            tick_q, tick_d;
  logic            irq_q, irq_d;
  logic            running_q, running_d;

  logic            wr_ctrl_c, wr_count_c, tick_kill_c, tick_go_c, match_c;
  logic [DW-1:0]   next_cnt_c;

  // Register read mux; returns pre-write values during a write cycle.
  always_comb begin
    cfg.cfg_rdata = '0;
    case (cfg.cfg_addr)
      A_CTRL:     cfg.cfg_rdata = {28'b0, (state_q == ST_DONE), irq_en_q, periodic_q, enable_q};
      A_PRESCALE: cfg.cfg_rdata = prescale_q;
      A_COMPARE:  cfg.cfg_rdata = compare_q;
      A_COUNT:    cfg.cfg_rdata = count_q;
      default:    cfg.cfg_rdata = '0;
    endcase
  end

  // Next-state: prescaler, counter, FSM, irq, with register writes winning.
  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    pre_d      = pre_q;
    count_d    = count_q;
    irq_d      = irq_q;
    tick_d     = 1'b0;

    wr_ctrl_c  = cfg.cfg_we && (cfg.cfg_addr == A_CTRL);
    wr_count_c = cfg.cfg_we && (cfg.cfg_addr == A_COUNT);
    // A COUNT write or a disabling CTRL write swallows a same-cycle tick.
    tick_kill_c = wr_count_c || (wr_ctrl_c && !cfg.cfg_wdata[0]);
    tick_go_c   = (state_q == ST_RUN) && (pre_q >= prescale_q) && !tick_kill_c;
    next_cnt_c  = count_q + DW'(1);
    match_c     = tick_go_c && (compare_q != '0) && (next_cnt_c == compare_q);

    if (state_q == ST_RUN) begin
      pre_d = (pre_q >= prescale_q) ? '0 : pre_q + DW'(1);
    end

    if (tick_go_c) begin
      tick_d = 1'b1;
      if (match_c) begin
        if (periodic_q) begin
          count_d = '0;
        end else begin
          count_d  = compare_q;
          state_d  = ST_DONE;
          enable_d = 1'b0;
        end
      end else begin
        count_d = next_cnt_c;
      end
    end

    // Set beats acknowledge.
    if (match_c && irq_en_q) begin
      irq_d = 1'b1;
    end else if (cfg.irq_ack) begin
      irq_d = 1'b0;
    end

    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        A_CTRL: begin
          enable_d   = cfg.cfg_wdata[0];
          periodic_d = cfg.cfg_wdata[1];
          irq_en_d   = cfg.cfg_wdata[2];
          if (cfg.cfg_wdata[0]) begin
            if (state_q != ST_RUN) begin
              state_d = ST_RUN;
              pre_d   = '0;
            end else begin
              state_d = ST_RUN;
            end
          end else if (state_q == ST_RUN) begin
            state_d = ST_IDLE;
            pre_d   = '0;
          end
        end
        A_PRESCALE: prescale_d = cfg.cfg_wdata;
        A_COMPARE:  compare_d  = cfg.cfg_wdata;
        A_COUNT: begin
          count_d = cfg.cfg_wdata;
          pre_d   = '0;
        end
        default: ;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= DW'(PRESCALE_RESET);
      compare_q  <= '0;
      pre_q      <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      irq_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      pre_q      <= pre_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      irq_q      <= irq_d;
      running_q  <= running_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign irq     = irq_q;
  assign running = running_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller: hand-computed expectations checked
// with immediate assertions at fixed cycle offsets from each enable edge.
module tb_timer_controller;

  logic        clock;
  logic        reset;
  logic [31:0] count;
  logic        tick;
  logic        irq;
  logic        running;

  int unsigned n_vec;
  int unsigned n_bad;

  timer_controller_if bus ();

  timer_controller #(.PRESCALE_RESET(49999)) dut (
    .clock   (clock),
    .reset   (reset),
    .cfg     (bus.slave),
    .count   (count),
    .tick    (tick),
    .irq     (irq),
    .running (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Single-cycle register write; returns 1ns after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    cyc(1);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.cfg_addr = a;
    #1;
    chk(tag, bus.cfg_rdata, exp);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 32'd0;
    bus.irq_ack   = 1'b0;
    reset = 1'b0;
    #23 reset = 1'b1;
    cyc(1);

    chk("rst_count",   count, 32'd0);
    chk("rst_irq",     32'(irq), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    rd("rst_prescale", 2'd1, 32'd49999);
    rd("rst_ctrl",     2'd0, 32'd0);

    // Free-run: PRESCALE=3, COMPARE=0
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h1);
    chk("fr_running", 32'(running), 32'd1);
    cyc(3);
    chk("fr_e3_count", count, 32'd0);
    chk("fr_e3_tick",  32'(tick), 32'd0);
    cyc(1);
    chk("fr_e4_count", count, 32'd1);
    chk("fr_e4_tick",  32'(tick), 32'd1);
    cyc(1);
    chk("fr_e5_tick",  32'(tick), 32'd0);
    cyc(3);
    chk("fr_e8_count", count, 32'd2);
    cyc(4);
    chk("fr_e12_count", count, 32'd3);
    chk("fr_irq",       32'(irq), 32'd0);
    wr(2'd0, 32'h0);
    chk("fr_stop_running", 32'(running), 32'd0);
    wr(2'd3, 32'd0);

    // Periodic with irq: PRESCALE=1, COMPARE=3
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h7);
    cyc(2);
    chk("per_e2_count", count, 32'd1);
    cyc(2);
    chk("per_e4_count", count, 32'd2);
    chk("per_e4_irq",   32'(irq), 32'd0);
    cyc(2);
    chk("per_e6_count", count, 32'd0);
    chk("per_e6_irq",   32'(irq), 32'd1);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    chk("per_ack_irq", 32'(irq), 32'd0);
    cyc(5);
    chk("per_e12_irq",   32'(irq), 32'd1);
    chk("per_e12_count", count, 32'd0);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    chk("per_ack2_irq", 32'(irq), 32'd0);
    cyc(4);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    chk("per_ack_vs_set_irq", 32'(irq), 32'd1);
    chk("per_e18_count",      count, 32'd0);
    wr(2'd0, 32'h0);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    wr(2'd3, 32'd0);

    // One-shot: PRESCALE=0, COMPARE=2
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h5);
    cyc(1);
    chk("os_e1_count",   count, 32'd1);
    chk("os_e1_running", 32'(running), 32'd1);
    cyc(1);
    chk("os_e2_count",   count, 32'd2);
    chk("os_e2_running", 32'(running), 32'd0);
    chk("os_e2_irq",     32'(irq), 32'd1);
    chk("os_e2_tick",    32'(tick), 32'd1);
    rd("os_ctrl", 2'd0, 32'hC);
    cyc(3);
    chk("os_hold_count", count, 32'd2);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;

    // COUNT write colliding with a tick: PRESCALE=3, COMPARE=0
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    cyc(3);
    wr(2'd3, 32'd10);
    chk("cw_count", count, 32'd10);
    chk("cw_tick",  32'(tick), 32'd0);
    cyc(3);
    chk("cw_e7_count", count, 32'd10);
    cyc(1);
    chk("cw_e8_count", count, 32'd11);
    chk("cw_e8_tick",  32'(tick), 32'd1);

    // CTRL=0 colliding with a tick
    cyc(3);
    wr(2'd0, 32'h0);
    chk("stop_count",   count, 32'd11);
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_tick",    32'(tick), 32'd0);
    rd("stop_ctrl", 2'd0, 32'h0);
    cyc(5);
    chk("stop_hold_count", count, 32'd11);

    // Wrap: 0xFFFFFFFF -> 0, no match with COMPARE=0
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h5);
    cyc(1);
    chk("wrap_count", count, 32'd0);
    chk("wrap_irq",   32'(irq), 32'd0);
    chk("wrap_tick",  32'(tick), 32'd1);
    wr(2'd0, 32'h0);

    // Asynchronous reset mid-run with irq pending
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h7);
    cyc(2);
    chk("ar_pre_irq", 32'(irq), 32'd1);
    cyc(1);
    chk("ar_pre_count", count, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_count",   count, 32'd0);
    chk("ar_irq",     32'(irq), 32'd0);
    chk("ar_tick",    32'(tick), 32'd0);
    chk("ar_running", 32'(running), 32'd0);
    rd("ar_prescale", 2'd1, 32'd49999);
    rd("ar_ctrl",     2'd0, 32'd0);
    rd("ar_compare",  2'd2, 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    chk("ar_after_count",   count, 32'd0);
    chk("ar_after_running", 32'(running), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
